// File: rtl/alu_exec_unit.sv
// Register file and three-state micro-sequencer wrapped around an external 8-bit ALU.
// Accepts one command at a time, drives the ALU for one cycle, and writes the result back with flags.
module alu_exec_unit #(
    parameter int REG_COUNT = 4,
    parameter int AW        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [7:0]    cmd_imm,
    output logic          alu_m,
    output logic [3:0]    alu_s,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    input  logic [7:0]    alu_t,
    input  logic          alu_cf,
    input  logic          alu_zf,
    output logic          flag_cf,
    output logic          flag_zf,
    output logic          done,
    input  logic [AW-1:0] dbg_sel,
    output logic [7:0]    dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [2:0] OP_LDI   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_NOT   = 3'd4;
    localparam logic [2:0] OP_MOV   = 3'd5;
    localparam logic [2:0] OP_PASSA = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    // {m, s} for each op; LDI and NOP leave the ALU idle.
    function automatic logic [4:0] alu_ctrl(input logic [2:0] op);
        case (op)
            OP_ADD:   alu_ctrl = 5'b1_1001;
            OP_SUB:   alu_ctrl = 5'b1_0110;
            OP_AND:   alu_ctrl = 5'b1_1011;
            OP_NOT:   alu_ctrl = 5'b1_0101;
            OP_MOV:   alu_ctrl = 5'b1_1010;
            OP_PASSA: alu_ctrl = 5'b0_1100;
            default:  alu_ctrl = 5'b0_0000;
        endcase
    endfunction

    state_t        state_p0, state_nxt;
    logic [7:0]    regs [REG_COUNT];
    logic [2:0]    op_p0;
    logic [AW-1:0] rd_p0;
    logic [7:0]    imm_p0, opa_p0, opb_p0;
    logic [7:0]    res_t_p1;
    logic          res_cf_p1, res_zf_p1;
    logic          accept;

    assign cmd_ready = (state_p0 == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_data  = regs[dbg_sel];

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LDI)      state_nxt = WB;
                    else if (cmd_op != OP_NOP) state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_m = 1'b0;
        alu_s = 4'b0000;
        alu_a = 8'h00;
        alu_b = 8'h00;
        if (state_p0 == EXEC) begin
            {alu_m, alu_s} = alu_ctrl(op_p0);
            alu_a          = opa_p0;
            alu_b          = opb_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0  <= IDLE;
            op_p0     <= OP_NOP;
            rd_p0     <= '0;
            imm_p0    <= 8'h00;
            opa_p0    <= 8'h00;
            opb_p0    <= 8'h00;
            res_t_p1  <= 8'h00;
            res_cf_p1 <= 1'b0;
            res_zf_p1 <= 1'b0;
            flag_cf   <= 1'b0;
            flag_zf   <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
        end else begin
            state_p0 <= state_nxt;
            done     <= (accept && cmd_op == OP_NOP) || (state_p0 == WB);
            // p0: command latch and operand snapshot
            if (accept) begin
                op_p0  <= cmd_op;
                rd_p0  <= cmd_rd;
                imm_p0 <= cmd_imm;
                opa_p0 <= regs[cmd_ra];
                opb_p0 <= regs[cmd_rb];
            end
            // p1: ALU result capture
            if (state_p0 == EXEC) begin
                res_t_p1  <= alu_t;
                res_cf_p1 <= alu_cf;
                res_zf_p1 <= alu_zf;
            end
            // p2: write-back; only arithmetic ops touch the flags
            if (state_p0 == WB) begin
                regs[rd_p0] <= (op_p0 == OP_LDI) ? imm_p0 : res_t_p1;
                if (op_p0 == OP_ADD || op_p0 == OP_SUB) begin
                    flag_cf <= res_cf_p1;
                    flag_zf <= res_zf_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed and random commands against an op-level reference model,
// with a behavioural ALU attached to the unit's ALU ports.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd7;
    logic [1:0] cmd_rd = 2'd0, cmd_ra = 2'd0, cmd_rb = 2'd0;
    logic [7:0] cmd_imm = 8'h00;
    logic       alu_m;
    logic [3:0] alu_s;
    logic [7:0] alu_a, alu_b, alu_t;
    logic       alu_cf, alu_zf;
    logic       flag_cf, flag_zf, done;
    logic [1:0] dbg_sel = 2'd0;
    logic [7:0] dbg_data;

    alu_exec_unit #(.REG_COUNT(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
        .flag_cf(flag_cf), .flag_zf(flag_zf), .done(done),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU for the modes the unit uses
    logic [8:0] sum9, dif9;
    assign sum9 = {1'b0, alu_a} + {1'b0, alu_b};
    assign dif9 = {1'b0, alu_b} - {1'b0, alu_a};
    always_comb begin
        alu_t  = 8'h00;
        alu_cf = 1'b0;
        case ({alu_m, alu_s})
            5'b1_1001: begin alu_t = sum9[7:0]; alu_cf = sum9[8]; end
            5'b1_0110: begin alu_t = dif9[7:0]; alu_cf = dif9[8]; end
            5'b1_1011: alu_t = alu_a & alu_b;
            5'b1_0101: alu_t = ~alu_b;
            5'b1_1010: alu_t = alu_b;
            5'b0_1100: alu_t = alu_a;
            default:   alu_t = 8'h00;
        endcase
    end
    assign alu_zf = (alu_t == 8'h00);

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        int          done_cyc;
        logic [31:0] regs;
        logic        cf;
        logic        zf;
    } exp_t;

    exp_t        sb[$];
    logic [20:0] exp_alu [int];
    logic [7:0]  m_regs [4];
    logic        m_cf, m_zf;
    logic [7:0]  seen_regs [4];
    logic        seen_cf, seen_zf;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: ALU drive every cycle, full state on every done pulse
    initial begin
        exp_t        e;
        logic [20:0] ea;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ea = exp_alu.exists(cnt) ? exp_alu[cnt] : 21'd0;
                chk("alu_drive", 32'({alu_m, alu_s, alu_a, alu_b}), 32'(ea));
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", 32'(cnt), 32'(e.done_cyc));
                        chk("ready_with_done", 32'(cmd_ready), 32'd1);
                        chk("flag_cf", 32'(flag_cf), 32'(e.cf));
                        chk("flag_zf", 32'(flag_zf), 32'(e.zf));
                        seen_cf = flag_cf;
                        seen_zf = flag_zf;
                        for (int i = 0; i < 4; i++) begin
                            dbg_sel = 2'(i);
                            #1;
                            chk($sformatf("reg%0d", i), 32'(dbg_data), 32'(e.regs[i*8 +: 8]));
                            seen_regs[i] = dbg_data;
                        end
                    end
                end else if (sb.size() > 0 && sb[0].done_cyc < cnt) begin
                    chk("done_missing", 32'(done), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_cf = 1'b0;
        m_zf = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm);
        int          w;
        int          c;
        int          lat;
        exp_t        e;
        logic [7:0]  a, b, r;
        logic [4:0]  ms;
        logic        wr, fl, cf;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            cmd_valid = 1'($urandom());
            cmd_op    = 3'($urandom());
            cmd_rd    = 2'($urandom());
            cmd_ra    = 2'($urandom());
            cmd_rb    = 2'($urandom());
            cmd_imm   = 8'($urandom());
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        c = cnt;
        a = m_regs[ra];
        b = m_regs[rb];
        r = 8'h00; cf = 1'b0; ms = 5'b0; wr = 1'b1; fl = 1'b0; lat = 2;
        case (op)
            3'd0: begin r = imm; lat = 1; end
            3'd1: begin r = a + b; cf = (int'(a) + int'(b)) > 255; ms = 5'b1_1001; fl = 1'b1; end
            3'd2: begin r = b - a; cf = (b < a); ms = 5'b1_0110; fl = 1'b1; end
            3'd3: begin r = a & b; ms = 5'b1_1011; end
            3'd4: begin r = ~b; ms = 5'b1_0101; end
            3'd5: begin r = b; ms = 5'b1_1010; end
            3'd6: begin r = a; ms = 5'b0_1100; end
            default: begin wr = 1'b0; lat = 0; end
        endcase
        if (op != 3'd0 && op != 3'd7) exp_alu[c] = {ms, a, b};
        if (wr) m_regs[rd] = r;
        if (fl) begin
            m_cf = cf;
            m_zf = (r == 8'h00);
        end
        e.done_cyc = c + lat;
        for (int i = 0; i < 4; i++) e.regs[i*8 +: 8] = m_regs[i];
        e.cf = m_cf;
        e.zf = m_zf;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({flag_cf, flag_zf}), 32'd0);
        chk("rst_alu", 32'({alu_m, alu_s, alu_a, alu_b}), 32'd0);
        rst_n = 1'b1;

        issue(3'd7, 2'd0, 2'd0, 2'd0, 8'h00);
        wait_idle();

        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'h05);
        issue(3'd0, 2'd1, 2'd0, 2'd0, 8'h03);
        issue(3'd1, 2'd2, 2'd0, 2'd1, 8'h00);
        wait_idle();
        chk("add_r2", 32'(seen_regs[2]), 32'h08);
        chk("add_flags", 32'({seen_cf, seen_zf}), 32'b00);

        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'hFF);
        issue(3'd0, 2'd1, 2'd0, 2'd0, 8'h01);
        issue(3'd1, 2'd3, 2'd0, 2'd1, 8'h00);
        wait_idle();
        chk("add_wrap_r3", 32'(seen_regs[3]), 32'h00);
        chk("add_wrap_flags", 32'({seen_cf, seen_zf}), 32'b11);
        issue(3'd3, 2'd2, 2'd0, 2'd1, 8'h00);
        wait_idle();
        chk("and_r2", 32'(seen_regs[2]), 32'h01);
        chk("and_flags_kept", 32'({seen_cf, seen_zf}), 32'b11);

        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'h05);
        issue(3'd0, 2'd1, 2'd0, 2'd0, 8'h03);
        issue(3'd2, 2'd2, 2'd0, 2'd1, 8'h00);
        wait_idle();
        chk("sub_r2", 32'(seen_regs[2]), 32'hFE);
        chk("sub_flags", 32'({seen_cf, seen_zf}), 32'b10);
        issue(3'd2, 2'd2, 2'd0, 2'd0, 8'h00);
        wait_idle();
        chk("sub_self", 32'(seen_regs[2]), 32'h00);
        chk("sub_self_flags", 32'({seen_cf, seen_zf}), 32'b01);

        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'h5A);
        issue(3'd4, 2'd1, 2'd2, 2'd0, 8'h00);
        wait_idle();
        chk("not_r1", 32'(seen_regs[1]), 32'hA5);
        issue(3'd5, 2'd1, 2'd3, 2'd0, 8'h00);
        wait_idle();
        chk("mov_r1", 32'(seen_regs[1]), 32'h5A);
        issue(3'd6, 2'd1, 2'd0, 2'd3, 8'h00);
        wait_idle();
        chk("passa_r1", 32'(seen_regs[1]), 32'h5A);
        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'h40);
        issue(3'd1, 2'd0, 2'd0, 2'd0, 8'h00);
        issue(3'd7, 2'd3, 2'd1, 2'd2, 8'hAA);
        wait_idle();
        chk("add_self_r0", 32'(seen_regs[0]), 32'h80);
        chk("nop_flags_kept", 32'({seen_cf, seen_zf}), 32'b00);

        for (int k = 0; k < 250; k++) begin
            logic [2:0] op;
            op = ($urandom_range(3, 0) == 0) ? 3'd0 : 3'($urandom());
            issue(op, 2'($urandom()), 2'($urandom()), 2'($urandom()), 8'($urandom()));
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of an ADD's EXEC cycle
        issue(3'd0, 2'd0, 2'd0, 2'd0, 8'h11);
        issue(3'd0, 2'd1, 2'd0, 2'd0, 8'h22);
        wait_idle();
        issue(3'd1, 2'd2, 2'd0, 2'd1, 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_alu.delete();
        model_reset();
        #1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_alu_s", 32'(alu_s), 32'd0);
        chk("midrst_alu_m", 32'(alu_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_done_after", 32'(done), 32'd0);
        issue(3'd7, 2'd0, 2'd0, 2'd0, 8'h00);
        wait_idle();
        chk("midrst_r2", 32'(seen_regs[2]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
